// File: rtl/layer_sequencer.sv
// layer_sequencer: drives one shared neuron stage once per neuron, storing ReLU+saturated results.
// Optional argmax outputs (max_idx/max_val) enabled by defining LAYER_SEQ_ARGMAX_EN.
module layer_sequencer #(
  parameter int M  = 10,
  parameter int W  = 16,
  parameter int OW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 neuron_ready,
  input  logic [W-1:0]         neuron_result,
  output logic                 neuron_start,
  output logic [$clog2(M)-1:0] neuron_idx,
  input  logic [$clog2(M)-1:0] rd_addr,
  output logic [OW-1:0]        rd_data,
  output logic                 busy,
  output logic                 done
`ifdef LAYER_SEQ_ARGMAX_EN
  ,
  output logic [$clog2(M)-1:0] max_idx,
  output logic [OW-1:0]        max_val
`endif
);
  localparam int IW = $clog2(M);
  localparam logic [IW-1:0] LP_LAST = IW'(M - 1);
  localparam logic [W-1:0]  LP_MAX  = W'((1 << OW) - 1);
  typedef enum logic [2:0] {IDLE, FIRE, WAIT, STORE, DONE} state_t;
  state_t         r_state, w_next;
  logic [IW-1:0]  r_idx;
  logic [OW-1:0]  r_buf [M];
  logic [W-1:0]   w_pos;
  logic [OW-1:0]  w_sat;
  logic           w_wr;
  assign w_pos = neuron_result[W-1] ? '0 : neuron_result;
  assign w_sat = (w_pos > LP_MAX) ? '1 : w_pos[OW-1:0];
  assign w_wr  = (r_state == WAIT) && neuron_ready;
  assign neuron_start = r_state == FIRE;
  assign busy         = (r_state == FIRE) || (r_state == WAIT) || (r_state == STORE);
  assign done         = r_state == DONE;
  assign neuron_idx   = r_idx;
  assign rd_data      = (rd_addr <= LP_LAST) ? r_buf[rd_addr] : '0;
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = start ? FIRE : IDLE;
      FIRE:    w_next = WAIT;
      WAIT:    w_next = neuron_ready ? STORE : WAIT;
      STORE:   w_next = (r_idx == LP_LAST) ? DONE : FIRE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      for (int i = 0; i < M; i++) r_buf[i] <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == STORE && r_idx != LP_LAST) r_idx <= r_idx + 1'b1;
      else if (r_state == DONE) r_idx <= '0;
      if (w_wr) r_buf[r_idx] <= w_sat;
    end
  end
`ifdef LAYER_SEQ_ARGMAX_EN
  logic [IW-1:0] r_max_idx;
  logic [OW-1:0] r_max_val;
  assign max_idx = r_max_idx;
  assign max_val = r_max_val;
  // strict compare keeps the lowest index on ties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max_idx <= '0;
      r_max_val <= '0;
    end else if (r_state == FIRE && r_idx == '0) begin
      r_max_idx <= '0;
      r_max_val <= '0;
    end else if (w_wr && w_sat > r_max_val) begin
      r_max_idx <= r_idx;
      r_max_val <= w_sat;
    end
  end
`endif
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: scoreboard bench for layer_sequencer (M=4); a neuron model answers 3 cycles after each start.
module tb_layer_sequencer;
  logic        clk, rst, start, neuron_ready, neuron_start, busy, done;
  logic [15:0] neuron_result;
  logic [1:0]  neuron_idx, rd_addr;
  logic [7:0]  rd_data;
`ifdef LAYER_SEQ_ARGMAX_EN
  logic [1:0]  max_idx;
  logic [7:0]  max_val;
`endif
  layer_sequencer #(.M(4), .W(16), .OW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .neuron_ready(neuron_ready),
    .neuron_result(neuron_result), .neuron_start(neuron_start), .neuron_idx(neuron_idx),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done)
`ifdef LAYER_SEQ_ARGMAX_EN
    , .max_idx(max_idx), .max_val(max_val)
`endif
  );
  typedef struct {
    int cyc;
    int b [4];
    int ns;
    int mi;
    int mv;
  } exp_t;
  exp_t q[$];
  int   checks = 0, failures = 0, cyc = 0;
  int   res [4];
  logic chk_req = 0, spur = 0;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial forever @(posedge clk) cyc++;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", n, a, e);
    end
  endtask
  task automatic push(input int c, input int b0, b1, b2, b3, input int mi, mv);
    exp_t e;
    e.cyc = c;
    e.b[0] = b0; e.b[1] = b1; e.b[2] = b2; e.b[3] = b3;
    e.ns = 4; e.mi = mi; e.mv = mv;
    q.push_back(e);
  endtask
  // neuron model: ready (with result) 3 cycles after each neuron_start; spur forces a stray ready of 77
  initial begin
    int cd, idx;
    cd = 0; idx = 0;
    neuron_ready = 0; neuron_result = 0;
    forever begin
      @(negedge clk);
      neuron_ready = 0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          neuron_ready = 1;
          neuron_result = 16'(res[idx]);
        end
      end
      if (spur) begin
        neuron_ready = 1;
        neuron_result = 16'd77;
      end
      if (neuron_start) begin
        cd = 3;
        idx = int'(neuron_idx);
      end
    end
  end
  // monitor: pops on done (or on a buffer-check request) and compares
  initial begin
    int ns_cnt, prev_ns;
    exp_t e;
    ns_cnt = 0; prev_ns = 0; rd_addr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ns_cnt = 0;
        prev_ns = 0;
      end else begin
        if (neuron_start) begin
          ns_cnt++;
          if (prev_ns != 0) chk("neuron_start_width", 2, 1);
        end
        prev_ns = int'(neuron_start);
      end
      if (done || chk_req) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          if (e.cyc >= 0) begin
            chk("done_cycle", cyc, e.cyc);
            chk("neuron_start_count", ns_cnt, e.ns);
            ns_cnt = 0;
`ifdef LAYER_SEQ_ARGMAX_EN
            chk("max_idx", int'(max_idx), e.mi);
            chk("max_val", int'(max_val), e.mv);
`endif
          end
          for (int k = 0; k < 4; k++) begin
            rd_addr = 2'(k);
            #1;
            chk($sformatf("buf%0d", k), int'(rd_data), e.b[k]);
          end
        end
      end
    end
  end
  task automatic buf_check(input int b0, b1, b2, b3);
    push(-1, b0, b1, b2, b3, 0, 0);
    @(posedge clk); #1 chk_req = 1;
    @(posedge clk); #1 chk_req = 0;
    wait_q();
  endtask
  task automatic wait_q();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("timeout_waiting_done", 1, 0);
      q.delete();
    end
    @(negedge clk);
  endtask
  task automatic idle_outputs(input string n);
    chk({n, "_neuron_start"}, int'(neuron_start), 0);
    chk({n, "_busy"}, int'(busy), 0);
    chk({n, "_done"}, int'(done), 0);
    chk({n, "_neuron_idx"}, int'(neuron_idx), 0);
  endtask
  task automatic simple_pass(input int r0, r1, r2, r3, b0, b1, b2, b3, mi, mv);
    res = '{r0, r1, r2, r3};
    @(negedge clk);
    start = 1;
    push(cyc + 21, b0, b1, b2, b3, mi, mv);
    @(negedge clk);
    start = 0;
    wait_q();
  endtask
  initial begin
    int s;
    rst = 1; start = 0;
    res = '{0, 0, 0, 0};
    repeat (3) @(negedge clk);
    idle_outputs("reset");
    rst = 0;
    buf_check(0, 0, 0, 0);
    simple_pass(10, -3, 300, 255, 10, 0, 255, 255, 2, 255);
    // starts while busy must be ignored
    res = '{20, 500, -1, 7};
    @(negedge clk);
    start = 1; s = cyc;
    push(s + 21, 20, 255, 0, 7, 1, 255);
    @(negedge clk);
    start = 0;
    while (cyc < s + 5) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    while (cyc < s + 12) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_q();
    repeat (30) @(negedge clk);
    // stray ready in IDLE
    @(posedge clk); #1 spur = 1;
    @(posedge clk); #1 spur = 0;
    @(negedge clk);
    chk("idle_spur_busy", int'(busy), 0);
    buf_check(20, 255, 0, 7);
    // stray ready in FIRE of neuron 0; new pass starts at index 0
    res = '{1, 2, 3, 4};
    @(negedge clk);
    start = 1; s = cyc;
    push(s + 21, 1, 2, 3, 4, 3, 4);
    @(posedge clk); #1;
    start = 0; spur = 1;
    chk("fire_neuron_start", int'(neuron_start), 1);
    chk("fire_idx0", int'(neuron_idx), 0);
    @(posedge clk); #1 spur = 0;
    chk("fire_spur_state", int'(busy), 1);
    wait_q();
    // reset during WAIT of neuron 2
    res = '{100, 100, 100, 100};
    @(negedge clk);
    start = 1; s = cyc;
    push(s + 21, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    start = 0;
    while (cyc < s + 12) @(negedge clk);
    chk("wait_n2_idx", int'(neuron_idx), 2);
    chk("wait_n2_busy", int'(busy), 1);
    rst = 1;
    #1;
    q.delete();
    idle_outputs("async_reset");
    repeat (2) @(negedge clk);
    rst = 0;
    buf_check(0, 0, 0, 0);
    repeat (10) @(negedge clk);
    simple_pass(50, -100, 256, 0, 50, 0, 255, 0, 2, 255);
    // start held high: two back-to-back passes
    res = '{0, 1, 128, 254};
    @(negedge clk);
    start = 1; s = cyc;
    push(s + 21, 0, 1, 128, 254, 3, 254);
    push(s + 43, 255, 255, 0, 255, 0, 255);
    while (cyc < s + 21) @(negedge clk);
    res = '{255, 256, -32768, 32767};
    while (cyc < s + 25) @(negedge clk);
    start = 0;
    wait_q();
    simple_pass(5, 90, 90, -1, 5, 90, 90, 0, 1, 90);
    repeat (5) @(negedge clk);
    chk("final_idle_busy", int'(busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
